// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: samples ws/sd on SCK strobes, assembles left/right words
// and presents stereo pairs on a valid/ready port. Define I2S_RX_OVERRUN_EN for overrun_o.
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_posedge_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef I2S_RX_OVERRUN_EN
  ,
  output logic                  overrun_o
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                  state, state_nxt;
  logic                    ws_q;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   acc, acc_bit, held_left, word_val;
  logic                    left_vld;
  logic [IW-1:0]           idx;
  logic                    boundary, capture, word_done, left_done, right_done, pair_fire;

  assign boundary = sck_posedge_i && (ws_i != ws_q);
  assign capture  = sck_posedge_i && !boundary && (state != IDLE) && (bit_cnt < CW'(DATA_WIDTH));
  // bits land directly in their final position, so a short word is already MSB-aligned
  assign idx      = IW'(DATA_WIDTH - 1) - bit_cnt[IW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (boundary) begin
      case (state)
        IDLE:    if (!ws_i) state_nxt = LEFT;
        LEFT:    if (ws_i)  state_nxt = RIGHT;
        RIGHT:   if (!ws_i) state_nxt = LEFT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_bit      = acc;
    acc_bit[idx] = sd_i;
    word_done    = 1'b0;
    word_val     = acc;
    if (boundary && (state != IDLE) && (bit_cnt != '0) && (bit_cnt < CW'(DATA_WIDTH))) begin
      word_done = 1'b1;
    end else if (capture && (bit_cnt == CW'(DATA_WIDTH - 1))) begin
      word_done = 1'b1;
      word_val  = acc_bit;
    end
    left_done  = word_done && (state == LEFT);
    right_done = word_done && (state == RIGHT);
    pair_fire  = right_done && left_vld;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ws_q      <= 1'b0;
      bit_cnt   <= '0;
      acc       <= '0;
      held_left <= '0;
      left_vld  <= 1'b0;
      left_o    <= '0;
      right_o   <= '0;
      valid_o   <= 1'b0;
    end else begin
      if (sck_posedge_i) ws_q <= ws_i;
      if (boundary) begin
        bit_cnt <= '0;
        acc     <= '0;
      end else if (capture) begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= acc_bit;
      end
      // a left word pairs with at most one right word
      if (left_done) begin
        held_left <= word_val;
        left_vld  <= 1'b1;
      end else if (pair_fire || (boundary && state_nxt == LEFT)) begin
        left_vld  <= 1'b0;
      end
      if (pair_fire && (!valid_o || ready_i)) begin
        left_o  <= held_left;
        right_o <= word_val;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVERRUN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  overrun_o <= 1'b0;
    else if (pair_fire && valid_o && !ready_i)  overrun_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer (DATA_WIDTH=16); checks overrun_o when I2S_RX_OVERRUN_EN is set.
module tb_i2s_rx_deserializer;
  logic        clk = 1'b0;
  logic        rst, sck, ws, sd, ready, valid;
  logic [15:0] left, right;
  logic        ovr;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  i2s_rx_deserializer #(.DATA_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .sck_posedge_i(sck), .ws_i(ws), .sd_i(sd),
    .left_o(left), .right_o(right), .valid_o(valid), .ready_i(ready)
`ifdef I2S_RX_OVERRUN_EN
    , .overrun_o(ovr)
`endif
  );
`ifndef I2S_RX_OVERRUN_EN
  assign ovr = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bit_edge(input logic w, input logic d);
    ws = w; sd = d; sck = 1'b1;
    @(posedge clk); #1;
    sck = 1'b0;
  endtask

  task automatic send_bit(input logic w, input logic d);
    bit_edge(w, d);
    idle(1);
  endtask

  task automatic send_data(input logic w, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(w, v[31-i]);
  endtask

  // one channel slot: boundary edge (not captured) followed by n-1 data edges
  task automatic send_chan(input logic w, input logic [31:0] v, input int n);
    send_bit(w, 1'b0);
    send_data(w, v, n - 1);
  endtask

  task automatic pulse_ready();
    ready = 1'b1; idle(1); ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b1;
    idle(3);
    check("rst_valid", valid, 0);
    check("rst_left", left, 0);
    check("rst_right", right, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    idle(2);

    // full 16-bit words, pair appears one clk after the right LSB edge
    send_chan(1'b1, 32'hFFFF_FFFF, 17);
    send_chan(1'b0, 32'hA5C3_0000, 17);
    send_chan(1'b1, 32'h3C5A_0000, 16);
    check("basic_pre_lsb_valid", valid, 0);
    bit_edge(1'b1, 1'b0);
    check("basic_valid", valid, 1);
    check("basic_left", left, 16'hA5C3);
    check("basic_right", right, 16'h3C5A);
    idle(1);
    check("basic_accept", valid, 0);

    // reset mid right word discards it; next pair is clean
    ready = 1'b0;
    send_chan(1'b0, 32'hAAAA_0000, 17);
    send_chan(1'b1, 32'hFFFF_0000, 6);
    rst = 1'b1; idle(2); rst = 1'b0;
    check("midrst_valid", valid, 0);
    send_data(1'b1, 32'hFFFF_0000, 11);
    check("midrst_discard", valid, 0);
    send_chan(1'b0, 32'h1234_0000, 17);
    send_chan(1'b1, 32'h5678_0000, 17);
    check("midrst_valid2", valid, 1);
    check("midrst_left", left, 16'h1234);
    check("midrst_right", right, 16'h5678);
    pulse_ready();

    // long channels: extra bits ignored
    send_chan(1'b0, 32'hFFFF_0000, 25);
    send_chan(1'b1, 32'h0F0F_0000, 25);
    check("long_valid", valid, 1);
    check("long_left", left, 16'hFFFF);
    check("long_right", right, 16'h0F0F);
    pulse_ready();
    check("long_accept", valid, 0);

    // short channels: 11 bits MSB-aligned, low bits zero
    send_chan(1'b0, 32'hABCD_0000, 12);
    send_chan(1'b1, 32'h5A5F_0000, 12);
    check("short_pending", valid, 0);
    bit_edge(1'b0, 1'b0);
    check("short_valid", valid, 1);
    check("short_left", left, 16'hABC0);
    check("short_right", right, 16'h5A40);
    idle(1);
    pulse_ready();

    // ready pulsed exactly as a new pair loads
    send_data(1'b0, 32'h5555_0000, 16);
    send_chan(1'b1, 32'h6666_0000, 17);
    check("swap_first_left", left, 16'h5555);
    check("swap_first_right", right, 16'h6666);
    send_chan(1'b0, 32'h7777_0000, 17);
    send_chan(1'b1, 32'h8888_0000, 16);
    check("swap_hold", left, 16'h5555);
    ready = 1'b1;
    bit_edge(1'b1, 1'b0);
    ready = 1'b0;
    check("swap_valid", valid, 1);
    check("swap_left", left, 16'h7777);
    check("swap_right", right, 16'h8888);
    check("swap_no_ovr", ovr, 0);
    idle(1);
    pulse_ready();
    check("swap_accept", valid, 0);

    // overrun: second pair dropped while first is held
    send_chan(1'b0, 32'h1111_0000, 17);
    send_chan(1'b1, 32'h2222_0000, 17);
    check("ovr_p1_valid", valid, 1);
    check("ovr_pre", ovr, 0);
    send_chan(1'b0, 32'h3333_0000, 17);
    send_chan(1'b1, 32'h4444_0000, 17);
    check("ovr_left", left, 16'h1111);
    check("ovr_right", right, 16'h2222);
    check("ovr_valid", valid, 1);
`ifdef I2S_RX_OVERRUN_EN
    check("ovr_flag", ovr, 1);
`endif
    pulse_ready();
    check("ovr_accept", valid, 0);

    // no strobes: toggling ws/sd must not disturb anything
    send_chan(1'b0, 32'h9A00_0000, 9);
    for (int i = 0; i < 100; i++) begin
      ws = i[0]; sd = i[1];
      idle(1);
    end
    check("quiet_valid", valid, 0);
    check("quiet_left", left, 16'h1111);
    check("quiet_right", right, 16'h2222);
    send_data(1'b0, 32'hBC00_0000, 8);
    send_chan(1'b1, 32'hDEF0_0000, 17);
    check("quiet_resume_valid", valid, 1);
    check("quiet_resume_left", left, 16'h9ABC);
    check("quiet_resume_right", right, 16'hDEF0);
`ifdef I2S_RX_OVERRUN_EN
    check("ovr_sticky", ovr, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
